seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 130 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit seven-segment scanner with a shadow register loaded once per frame.
// Optional leading-zero blanking is enabled with the SEG7_LZB_EN macro.
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] num,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt_reg;
  logic [1:0]    idx_reg;
  logic [15:0]   shadow_reg;
  logic [3:0]    shadow_dp_reg;

  logic          tick;
  logic          slot_blank;
  logic [3:0]    digits [4];
  logic [3:0]    digit;
  logic [3:0]    lz_blank;
  logic [6:0]    seg_next;
  logic [3:0]    an_next;
  logic          dp_next;
  logic          frame_next;

  assign tick       = (cnt_reg == CW'(SCAN_DIV - 1));
  assign frame_next = tick && (idx_reg == 2'd3);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign digits[gi] = shadow_reg[gi*4 +: 4];
    end
  endgenerate

  assign digit = digits[idx_reg];

  // A zero blanking window must not produce an always-false unsigned compare.
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign slot_blank = 1'b0;
    end else begin : g_blank
      assign slot_blank = (cnt_reg < CW'(BLANK_CYC));
    end
  endgenerate

`ifdef SEG7_LZB_EN
  // Each digit is blank only if it and every digit to its left are zero.
  assign lz_blank[3] = (digits[3] == 4'd0);
  assign lz_blank[2] = lz_blank[3] && (digits[2] == 4'd0);
  assign lz_blank[1] = lz_blank[2] && (digits[1] == 4'd0);
  assign lz_blank[0] = 1'b0;
`else
  assign lz_blank = 4'b0000;
`endif

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  always_comb begin
    seg_next = decode(digit);
    an_next  = ~(4'b0001 << idx_reg);
    dp_next  = ~shadow_dp_reg[idx_reg];
    if (lz_blank[idx_reg]) begin
      seg_next = 7'h7F;
    end
    if (slot_blank) begin
      an_next = 4'hF;
      dp_next = 1'b1;
    end
  end

  // Prescaler, slot index and once-per-frame shadow capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      idx_reg       <= 2'd0;
      shadow_reg    <= 16'h0000;
      shadow_dp_reg <= 4'h0;
      frame         <= 1'b0;
    end else begin
      frame <= frame_next;
      if (tick) begin
        cnt_reg <= '0;
        idx_reg <= idx_reg + 2'd1;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
      if (frame_next) begin
        shadow_reg    <= num;
        shadow_dp_reg <= dp_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= 4'hF;
    end else begin
      seg <= seg_next;
      dp  <= dp_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-indexed reference model predicts every output cycle.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME_LEN = 4 * SCAN_DIV;

  logic        clk;
  logic        rst_n;
  logic [15:0] num;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  int errors = 0;
  int checks = 0;

  logic [12:0] exp_q [$];
  logic [6:0]  lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  int          k = 0;
  logic [15:0] m_shadow = 16'h0;
  logic [3:0]  m_sdp = 4'h0;

  seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .num(num), .dp_in(dp_in),
    .seg(seg), .dp(dp), .an(an), .frame(frame)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Reference model: outputs after edge number p+1 show the state reached after p edges.
  always @(posedge clk) begin
    int p, c, ix;
    logic [3:0] d;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic e_dp, e_fr;
    if (!rst_n) begin
      k = 0;
      m_shadow = 16'h0;
      m_sdp = 4'h0;
      exp_q.push_back({1'b0, 4'hF, 1'b1, 7'h7F});
    end else begin
      p = k;
      k++;
      c  = p % SCAN_DIV;
      ix = (p / SCAN_DIV) % 4;
      d = m_shadow[ix*4 +: 4];
      e_seg = lut[d];
`ifdef SEG7_LZB_EN
      if (ix > 0 && (m_shadow >> (ix * 4)) == 16'h0) e_seg = 7'h7F;
`endif
      e_an = (c < BLANK_CYC) ? 4'hF : ~(4'b0001 << ix);
      e_dp = (e_an == 4'hF) ? 1'b1 : ~m_sdp[ix];
      e_fr = ((p % FRAME_LEN) == FRAME_LEN - 1);
      if (e_fr) begin
        m_shadow = num;
        m_sdp = dp_in;
      end
      exp_q.push_back({e_fr, e_an, e_dp, e_seg});
    end
  end

  // Monitor: one line per transaction that disagrees, plus the anode legality check.
  always @(negedge clk) begin
    logic [12:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({frame, an, dp, seg} !== e) begin
        errors++;
        $display("FAIL out: got frame=%b an=%h dp=%b seg=%h, expected frame=%b an=%h dp=%b seg=%h",
                 frame, an, dp, seg, e[12], e[11:8], e[7], e[6:0]);
      end
      checks++;
      if (!(an inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7})) begin
        errors++;
        $display("FAIL an_legal: got %h, expected F or one-hot-low", an);
      end
    end
  end

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((k % FRAME_LEN) != ph && n < 100);
    check("phase_wait", 16'(n < 100), 16'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    num   = 16'h1234;
    dp_in = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_seg", 16'(seg), 16'h7F);
    check("reset_an", 16'(an), 16'hF);
    rst_n = 1'b1;

    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (frame) break;
    end
    check("first_frame_latency", 16'(n), 16'd16);

    // Mid-frame change must not tear the displayed value.
    repeat (20) @(negedge clk);
    wait_phase(6);
    num = 16'h5678;
    repeat (40) @(negedge clk);

    num   = 16'h00A7;
    dp_in = 4'b0100;
    repeat (40) @(negedge clk);

    // Asynchronous reset pulse while slot 2 is active.
    wait_phase(9);
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_an", 16'(an), 16'hF);
    check("async_seg", 16'(seg), 16'h7F);
    check("async_dp", 16'(dp), 16'h1);
    check("async_frame", 16'(frame), 16'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    num   = 16'h0000;
    dp_in = 4'h0;
    repeat (50) @(negedge clk);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        num   = 16'($urandom);
        dp_in = 4'($urandom);
      end
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
